// File: rtl/sbox_sched_pkg.sv
// rtl/sbox_sched_pkg.sv - shared types and constants for the S-box byte scheduler
package sbox_sched_pkg;

   localparam int NUM_BYTES = 16;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } schedStateT;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tokenT;

   localparam int TOKEN_W = 1 + IDX_W;

endpackage

// File: rtl/sbox_byte_scheduler_if.sv
// rtl/sbox_byte_scheduler_if.sv - control, state, randomness and S-box signals of the scheduler
interface sbox_byte_scheduler_if #(
   parameter int SHARES = 2,
   parameter int RAND_W = 18
);

   logic                   StartxSI;
   logic                   ReadyxSO;
   logic                   BusyxSO;
   logic                   DonexSO;
   logic [128*SHARES-1:0]  StatexDI;
   logic [128*SHARES-1:0]  StatexDO;
   logic                   RandReqxSO;
   logic                   RandValidxSI;
   logic [RAND_W-1:0]      RandxDI;
   logic [8*SHARES-1:0]    SboxInxDO;
   logic [RAND_W-1:0]      SboxRandxDO;
   logic [8*SHARES-1:0]    SboxOutxDI;

   modport master (
      output StartxSI, StatexDI, RandValidxSI, RandxDI, SboxOutxDI,
      input  ReadyxSO, BusyxSO, DonexSO, StatexDO, RandReqxSO, SboxInxDO, SboxRandxDO
   );

   modport slave (
      input  StartxSI, StatexDI, RandValidxSI, RandxDI, SboxOutxDI,
      output ReadyxSO, BusyxSO, DonexSO, StatexDO, RandReqxSO, SboxInxDO, SboxRandxDO
   );

endinterface

// File: rtl/sbox_token_pipe.sv
// rtl/sbox_token_pipe.sv - fixed-depth shift register tracking bytes in flight through the S-box
module sbox_token_pipe #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 5
) (
   input  logic             ClkxCI,
   input  logic             RstxBI,
   input  logic [WIDTH-1:0] TokenxDI,
   output logic [WIDTH-1:0] HeadxDO
);

   logic [WIDTH-1:0] pipeQ [DEPTH];

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipeQ[i] <= '0;
         end
      end else begin
         pipeQ[0] <= TokenxDI;
         for (int i = 1; i < DEPTH; i++) begin
            pipeQ[i] <= pipeQ[i-1];
         end
      end
   end

   assign HeadxDO = pipeQ[DEPTH-1];

endmodule

// File: rtl/sbox_byte_scheduler.sv
// rtl/sbox_byte_scheduler.sv - feeds the 16 bytes of a masked state through one shared pipelined S-box
module sbox_byte_scheduler
   import sbox_sched_pkg::*;
#(
   parameter int SHARES       = 2,
   parameter int SBOX_LATENCY = 5,
   parameter int RAND_W       = 18
) (
   input  logic                 ClkxCI,
   input  logic                 RstxBI,
   sbox_byte_scheduler_if.slave bus
);

   schedStateT             stateQ;
   logic                   readyQ;
   logic                   busyQ;
   logic                   doneQ;
   logic                   randReqQ;
   logic [CNT_W-1:0]       issueCntQ;
   logic [CNT_W-1:0]       retCntQ;
   logic [128*SHARES-1:0]  workQ;
   logic [128*SHARES-1:0]  workNext;
   logic [128*SHARES-1:0]  stateOutQ;
   logic [8*SHARES-1:0]    sboxInQ;
   logic [RAND_W-1:0]      sboxRandQ;
   logic [8*SHARES-1:0]    issueByte;
   logic [IDX_W-1:0]       issueIdx;
   logic                   issueFire;
   logic                   lastIssue;
   logic                   headWrite;
   logic                   lastReturn;
   tokenT                  pushTok;
   tokenT                  headTok;
   logic [TOKEN_W-1:0]     headBits;

   assign issueIdx   = issueCntQ[IDX_W-1:0];
   assign issueFire  = (stateQ == ISSUE) && bus.RandValidxSI;
   assign lastIssue  = issueFire && (issueCntQ == CNT_W'(NUM_BYTES - 1));
   assign headTok    = headBits;
   assign headWrite  = headTok.valid && ((stateQ == ISSUE) || (stateQ == DRAIN));
   assign lastReturn = headWrite && (retCntQ == CNT_W'(NUM_BYTES - 1));

   // Bubbles carry an invalid token so the head stays aligned with the S-box output.
   always_comb begin
      pushTok.valid = issueFire;
      pushTok.idx   = issueFire ? issueIdx : '0;
   end

   always_comb begin
      issueByte = '0;
      for (int s = 0; s < SHARES; s++) begin
         issueByte[8*s +: 8] = workQ[128*s + 8*int'(issueIdx) +: 8];
      end
   end

   // A byte is only written back after it has been issued, so results reuse the work register.
   always_comb begin
      workNext = workQ;
      if (headWrite) begin
         for (int s = 0; s < SHARES; s++) begin
            workNext[128*s + 8*int'(headTok.idx) +: 8] = bus.SboxOutxDI[8*s +: 8];
         end
      end
   end

   sbox_token_pipe #(
      .DEPTH (SBOX_LATENCY + 1),
      .WIDTH (TOKEN_W)
   ) tokenPipe (
      .ClkxCI   (ClkxCI),
      .RstxBI   (RstxBI),
      .TokenxDI (pushTok),
      .HeadxDO  (headBits)
   );

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         stateQ    <= IDLE;
         readyQ    <= 1'b1;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
         randReqQ  <= 1'b0;
         issueCntQ <= '0;
         retCntQ   <= '0;
         workQ     <= '0;
         stateOutQ <= '0;
         sboxInQ   <= '0;
         sboxRandQ <= '0;
      end else begin
         // Idle cycles drive zeros so no stale share value reaches the S-box twice.
         sboxInQ   <= issueFire ? issueByte : '0;
         sboxRandQ <= issueFire ? bus.RandxDI : '0;
         doneQ     <= 1'b0;
         workQ     <= workNext;
         if (issueFire) begin
            issueCntQ <= issueCntQ + 1'b1;
         end
         if (headWrite) begin
            retCntQ <= retCntQ + 1'b1;
         end

         case (stateQ)
            IDLE: begin
               if (bus.StartxSI) begin
                  workQ     <= bus.StatexDI;
                  issueCntQ <= '0;
                  retCntQ   <= '0;
                  readyQ    <= 1'b0;
                  busyQ     <= 1'b1;
                  randReqQ  <= 1'b1;
                  stateQ    <= ISSUE;
               end
            end
            ISSUE: begin
               if (lastIssue) begin
                  randReqQ <= 1'b0;
                  stateQ   <= DRAIN;
               end
            end
            DRAIN: begin
               if (lastReturn) begin
                  stateOutQ <= workNext;
                  busyQ     <= 1'b0;
                  doneQ     <= 1'b1;
                  stateQ    <= DONE;
               end
            end
            DONE: begin
               readyQ <= 1'b1;
               stateQ <= IDLE;
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign bus.ReadyxSO    = readyQ;
   assign bus.BusyxSO     = busyQ;
   assign bus.DonexSO     = doneQ;
   assign bus.RandReqxSO  = randReqQ;
   assign bus.StatexDO    = stateOutQ;
   assign bus.SboxInxDO   = sboxInQ;
   assign bus.SboxRandxDO = sboxRandQ;

endmodule

// File: tb/tb_sbox_byte_scheduler.sv
// tb/tb_sbox_byte_scheduler.sv - directed scoreboard bench for the S-box byte scheduler
module tb_sbox_byte_scheduler;

   localparam logic [7:0] SBOX_T [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [127:0] S1_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] S1_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [127:0] P3     = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] M3     = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] S3_OUT = 128'h1628c14beaaceec4f533fc1bc3938263;

   typedef struct {
      bit           recomb;
      logic [255:0] exp;
      int           doneCyc;
   } expT;

   logic clk;
   logic rstn;
   int   cyc = 0;
   int   compared = 0;
   int   failed = 0;
   int   t0;
   expT  expQ[$];
   expT  cur;
   logic [7:0] mdl0 [5];
   logic [7:0] mdl1 [5];

   sbox_byte_scheduler_if #(.SHARES(2), .RAND_W(18)) bus ();

   sbox_byte_scheduler #(
      .SHARES       (2),
      .SBOX_LATENCY (5),
      .RAND_W       (18)
   ) dut (
      .ClkxCI (clk),
      .RstxBI (rstn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External 5-stage S-box: share1 passes through as the output mask.
   always @(posedge clk) begin
      mdl0[0] <= SBOX_T[bus.SboxInxDO[7:0] ^ bus.SboxInxDO[15:8]] ^ bus.SboxInxDO[15:8];
      mdl1[0] <= bus.SboxInxDO[15:8];
      for (int i = 1; i < 5; i++) begin
         mdl0[i] <= mdl0[i-1];
         mdl1[i] <= mdl1[i-1];
      end
   end
   assign bus.SboxOutxDI = {mdl1[4], mdl0[4]};

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rstn && bus.DonexSO) begin
         if (expQ.size() == 0) begin
            chk("unexpected_done_cycle", 256'(cyc), 256'hffffffff);
         end else begin
            cur = expQ.pop_front();
            chk("done_cycle", 256'(cyc), 256'(cur.doneCyc));
            if (cur.recomb) begin
               chk("state_recombined", {128'h0, bus.StatexDO[127:0] ^ bus.StatexDO[255:128]}, cur.exp);
            end else begin
               chk("state_shares", bus.StatexDO, cur.exp);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0;
      bus.StartxSI = 1'b0;
      bus.StatexDI = '0;
      bus.RandValidxSI = 1'b0;
      bus.RandxDI = '0;
      repeat (3) step();
      chk("rst_ready", bus.ReadyxSO, 1);
      chk("rst_busy", bus.BusyxSO, 0);
      chk("rst_randreq", bus.RandReqxSO, 0);
      chk("rst_sboxin", bus.SboxInxDO, 0);
      chk("rst_state", bus.StatexDO, 0);
      rstn = 1'b1;
      step();

      // 1: contiguous randomness
      bus.StatexDI = {128'h0, S1_IN};
      bus.RandxDI = 18'h00001;
      bus.RandValidxSI = 1'b1;
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b0, exp: {128'h0, S1_OUT}, doneCyc: t0 + 23});
      step();
      bus.StartxSI = 1'b0;
      bus.RandxDI = 18'h2a5a5;
      chk("s1_ready_t1", bus.ReadyxSO, 0);
      chk("s1_busy_t1", bus.BusyxSO, 1);
      chk("s1_randreq_t1", bus.RandReqxSO, 1);
      step();
      bus.RandxDI = 18'h15a5a;
      chk("s1_sboxrand_t2", bus.SboxRandxDO, 18'h2a5a5);
      step();
      chk("s1_sboxin_t3", bus.SboxInxDO, 16'h0001);
      chk("s1_sboxrand_t3", bus.SboxRandxDO, 18'h15a5a);
      repeat (25) step();
      chk("s1_pending", expQ.size(), 0);

      // 2: randomness valid only in odd cycles
      bus.RandValidxSI = 1'b0;
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b0, exp: {128'h0, S1_OUT}, doneCyc: t0 + 38});
      for (int k = 1; k <= 45; k++) begin
         step();
         bus.StartxSI = 1'b0;
         bus.RandValidxSI = (k % 2 == 1) && (k <= 31);
         if (k == 3) chk("s2_sboxin_t3", bus.SboxInxDO, 0);
         if (k == 4) chk("s2_sboxin_t4", bus.SboxInxDO, 16'h0001);
         if (k == 5) chk("s2_sboxin_t5", bus.SboxInxDO, 0);
      end
      chk("s2_pending", expQ.size(), 0);

      // 3: nonzero masks, ready profile
      bus.StatexDI = {M3, P3 ^ M3};
      bus.RandValidxSI = 1'b1;
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b1, exp: {128'h0, S3_OUT}, doneCyc: t0 + 23});
      for (int k = 1; k <= 30; k++) begin
         step();
         bus.StartxSI = 1'b0;
         if (k <= 24) chk($sformatf("s3_ready_t%0d", k), bus.ReadyxSO, k == 24);
      end
      chk("s3_pending", expQ.size(), 0);

      // 4: start ignored mid-operation and in the done cycle
      bus.StatexDI = {128'h0, S1_IN};
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b0, exp: {128'h0, S1_OUT}, doneCyc: t0 + 23});
      for (int k = 1; k <= 60; k++) begin
         step();
         bus.StartxSI = (k == 5) || (k == 23);
         if (k == 5) bus.StatexDI = {128'h0, {16{8'hff}}};
         if (k == 23) bus.StatexDI = {{16{8'h5a}}, {16{8'ha5}}};
      end
      chk("s4_pending", expQ.size(), 0);

      // 5: asynchronous reset mid-issue
      bus.StatexDI = {M3, P3 ^ M3};
      bus.StartxSI = 1'b1;
      step();
      bus.StartxSI = 1'b0;
      repeat (7) step();
      rstn = 1'b0;
      #1;
      chk("s5_ready", bus.ReadyxSO, 1);
      chk("s5_busy", bus.BusyxSO, 0);
      chk("s5_done", bus.DonexSO, 0);
      chk("s5_randreq", bus.RandReqxSO, 0);
      chk("s5_sboxin", bus.SboxInxDO, 0);
      chk("s5_sboxrand", bus.SboxRandxDO, 0);
      chk("s5_state", bus.StatexDO, 0);
      step();
      step();
      rstn = 1'b1;
      step();
      bus.StatexDI = {128'h0, S1_IN};
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b0, exp: {128'h0, S1_OUT}, doneCyc: t0 + 23});
      step();
      bus.StartxSI = 1'b0;
      repeat (28) step();
      chk("s5_pending", expQ.size(), 0);

      // 6: randomness starved for 40 cycles
      bus.StatexDI = {M3, P3 ^ M3};
      bus.RandValidxSI = 1'b0;
      bus.StartxSI = 1'b1;
      t0 = cyc;
      expQ.push_back('{recomb: 1'b1, exp: {128'h0, S3_OUT}, doneCyc: t0 + 63});
      for (int k = 1; k <= 70; k++) begin
         step();
         bus.StartxSI = 1'b0;
         bus.RandValidxSI = (k >= 41);
         if (k == 20 || k == 40) begin
            chk($sformatf("s6_randreq_t%0d", k), bus.RandReqxSO, 1);
            chk($sformatf("s6_busy_t%0d", k), bus.BusyxSO, 1);
            chk($sformatf("s6_sboxin_t%0d", k), bus.SboxInxDO, 0);
         end
      end
      chk("s6_pending", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/sbox_byte_scheduler.md
Name: sbox_byte_scheduler

Overview:
- Sequences one shared, pipelined, DOM-masked AES S-box over all 16 bytes of a masked 128-bit state (SubBytes step).
- The S-box, including its input/output linear maps, is instantiated outside this block and has no enable.
- This block captures the shared state, issues one byte per cycle whenever fresh randomness is valid, and tracks in-flight bytes with a token pipe.
- It writes results back by byte index and signals completion with a ready/start/done handshake.

Parameters:
- SHARES, 2, number of Boolean shares per byte (2 = first-order DOM).
- SBOX_LATENCY, 5, cycles from a value on SboxInxDO to its result on SboxOutxDI.
- RAND_W, 18, fresh-randomness bits the S-box consumes per issued byte.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- StartxSI  in  1  start request; sampled only when ReadyxSO=1.
- ReadyxSO  out  1  idle, will accept StartxSI.
- BusyxSO  out  1  operation in progress.
- DonexSO  out  1  one-cycle pulse; StatexDO is valid.
- StatexDI  in  128*SHARES  masked state; share s at [128*s +: 128]; byte i of share s at [128*s+8*i +: 8].
- StatexDO  out  128*SHARES  substituted state, same layout.
- RandReqxSO  out  1  randomness wanted this cycle.
- RandValidxSI  in  1  RandxDI is fresh; consumed in the cycle RandReqxSO & RandValidxSI.
- RandxDI  in  RAND_W  fresh randomness.
- SboxInxDO  out  8*SHARES  registered S-box input; share s at [8*s +: 8].
- SboxRandxDO  out  RAND_W  registered randomness, aligned with SboxInxDO.
- SboxOutxDI  in  8*SHARES  S-box result, same share layout.

Behaviour:
- Reset (async, RstxBI=0):
  - State=IDLE; ReadyxSO=1; BusyxSO=0; DonexSO=0; RandReqxSO=0.
  - SboxInxDO=0; SboxRandxDO=0; StatexDO=0.
  - Token pipe cleared; all counters 0.
  - Reset mid-operation aborts the operation with no residual tokens.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - ReadyxSO=1.
  - If StartxSI=1: capture StatexDI into the work register, clear IssueCnt and RetCnt, go to ISSUE.
- ISSUE:
  - RandReqxSO=1, BusyxSO=1.
  - Each cycle with RandValidxSI=1, at the clock edge:
    - SboxInxDO <= byte IssueCnt of every share.
    - SboxRandxDO <= RandxDI.
    - Push token {valid=1, idx=IssueCnt}; IssueCnt++.
  - Cycle with RandValidxSI=0 (bubble): SboxInxDO and SboxRandxDO <= all-zero; push an invalid token. Masking hygiene: stale shares are never re-driven.
  - After issue of byte 15, go to DRAIN.
- DRAIN:
  - RandReqxSO=0; bubbles are issued (zero inputs, invalid tokens).
  - Exit when RetCnt reaches 16.
- Token pipe:
  - Depth SBOX_LATENCY+1.
  - A token pushed at the end of cycle c is at the head in cycle c+1+SBOX_LATENCY.
  - In that cycle, if the token is valid, SboxOutxDI is written to result byte idx (all shares) and RetCnt++.
  - The write can occur in the ISSUE or DRAIN state.
- DONE:
  - DonexSO=1 for exactly one cycle; StatexDO holds the results.
  - Go to IDLE.
  - StatexDO stays stable until the next completed operation; it is updated only at the DONE transition, not byte-by-byte.
- StartxSI outside IDLE (ISSUE, DRAIN or DONE) is ignored; no queuing.
- Latency:
  - Start sampled at the end of cycle T0; first possible issue in T1.
  - With RandValidxSI held high, DonexSO is high in cycle T18+SBOX_LATENCY.
  - In general, DonexSO is high in cycle Tlast+2+SBOX_LATENCY, where Tlast is the 16th randomness-valid cycle.
- Widths: IssueCnt and RetCnt are 5 bits (0..16). The byte index is 4 bits and does not wrap within an operation.

Decomposition:
- Package sbox_sched_pkg:
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
  - NUM_BYTES=16; IDX_W=4; CNT_W=5.
  - Token type {valid, idx}.
- Sub-module sbox_token_pipe:
  - Parameterised shift register (DEPTH, token width).
  - Async active-low clear.
  - Outputs the head token.

Test Plan:
All scenarios use SHARES=2, SBOX_LATENCY=5, and a behavioural 5-cycle S-box model at the bench.
1. Share1=0, share0 bytes 00..0F; Start in T0; RandValidxSI=1 always -> DonexSO only in T23; StatexDO share0 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76 (byte 0 first); share1=0.
2. Same data; RandValidxSI high only in odd cycles T1,T3..T31 -> SboxInxDO=0 in the cycles after even ones; DonexSO in T38; same result as scenario 1.
3. Random nonzero masks: share1 = M, share0 = P^M; bench S-box recombines -> share0^share1 of StatexDO equals SubBytes(P); ReadyxSO=0 from T1 until the cycle after DonexSO.
4. StartxSI pulsed in T5 and during the DONE cycle with a different StatexDI -> ignored; result matches the first capture; no second DonexSO.
5. RstxBI low in T8 mid-ISSUE -> all outputs at reset values immediately; after release, a fresh Start completes normally with no extra result writes from old tokens.
6. RandValidxSI=0 for 40 cycles after Start -> RandReqxSO stays 1; no tokens issued; BusyxSO=1; no DonexSO; resuming continues from byte 0.
